lcd_bus_driver: RTL and testbench
=================================

# lcd_bus_driver

Byte-level LCD bus driver for the scope's HD44780-class character display. It sits directly downstream of the LCD main controller and turns each `lcd_enable` request into a burst of timed bus writes: 4 bytes in init mode, 16 bytes in refresh mode. It drives E/RS/RW/DB with compliant setup, pulse and execution-wait timing, indexes the upstream data mux via `data_idx`, and reports burst completion on `lcd_finish`.

## Interface
- `INIT_BYTES`, 4: bytes per burst when `mode`=1
- `REF_BYTES`, 16: bytes per burst when `mode`=0; max 16
- `SETUP_CYC`, 2: cycles DB/RS are stable before E rises
- `E_HIGH_CYC`, 12: E high width in cycles
- `CMD_WAIT_CYC`, 2000: post-E wait for a normal byte (40 µs @ 50 MHz)
- `CLR_WAIT_CYC`, 82000: post-E wait for command 0x01 or 0x02 with RS=0
- `PWR_WAIT_CYC`, 750000: power-on delay (15 ms @ 50 MHz)
- `clk` in 1: system clock; all logic on rising edge
- `rst` in 1: reset; synchronous and active-low
- `lcd_enable` in 1: burst start request, sampled only in IDLE
- `mode` in 1: 1 = init burst, 0 = refresh burst; latched at start
- `reg_sel` in 1: RS value for the burst; latched at start
- `data_in` in 8: byte for the current index, from the upstream mux
- `data_idx` out 4: index of the byte being sent
- `lcd_finish` out 1: one-cycle pulse when a burst completes
- `busy` out 1: high from burst acceptance until `lcd_finish`
- `LCD_E` out 1, `LCD_RS` out 1, `LCD_RW` out 1 (tied 0), `LCD_DB` out 8

## Operation
- States: PWRUP, IDLE, SETUP, PULSE, WAIT, DONE.
- Reset (`rst`=0 at an edge): state → PWRUP (or IDLE, see Configuration). Outputs: `LCD_E`=0, `LCD_RS`=0, `LCD_RW`=0, `LCD_DB`=0x00, `data_idx`=0, `lcd_finish`=0, `busy`=0. Counters clear. Reset mid-burst aborts it; E drops on that same edge and no `lcd_finish` is produced.
- IDLE with `lcd_enable`=1:
  - latch `mode` and `reg_sel`;
  - set `data_idx`=0 and byte count N=`INIT_BYTES` or `REF_BYTES`;
  - `busy`=1; go to SETUP.
- SETUP: register `LCD_DB`←`data_in` and `LCD_RS`←latched RS on entry. Count `SETUP_CYC` cycles, then go to PULSE.
- PULSE: `LCD_E`=1 for `E_HIGH_CYC` cycles, then E=0 and go to WAIT.
- WAIT: hold DB/RS stable. The wait length is `CLR_WAIT_CYC` if RS=0 and byte ∈ {0x01,0x02}; otherwise it is `CMD_WAIT_CYC`. At wait end:
  - if `data_idx`=N−1, go to DONE;
  - otherwise increment `data_idx` and go to SETUP.
- DONE: one cycle. `lcd_finish` is registered high for exactly one cycle, `busy`←0, and the state returns to IDLE on that same edge. `data_idx` returns to 0.
- `lcd_enable` is ignored outside IDLE. A request in the cycle `lcd_finish` is high is accepted, because the state is already IDLE.
- Wait counter: 20-bit, counting down to 0. No wrap; it reloads on each phase entry.

## Timing
- `lcd_enable` sampled at edge k → DB/RS valid after edge k+1. E rises at edge k+1+`SETUP_CYC`.
- Byte period = `SETUP_CYC` + `E_HIGH_CYC` + wait length.
- `lcd_finish` rises one cycle after the last byte's wait ends.
- `data_in` is sampled once per byte, at the edge entering SETUP. The upstream mux has one cycle after `data_idx` changes.
- Upstream may assert `lcd_enable` one cycle after `lcd_finish` with no stall.

## Configuration
- `LCD_POWERON_WAIT_EN` defined:
  - after reset the driver sits in PWRUP for `PWR_WAIT_CYC` cycles, then enters IDLE;
  - `busy`=1 during PWRUP;
  - an `lcd_enable` during PWRUP is held as pending and starts the burst on the first IDLE cycle, using `mode`/`reg_sel` captured with the request.
- Not defined: the PWRUP state is removed and reset goes straight to IDLE.

## Structure
- Shared package `lcd_pkg`:
  - state enum;
  - `LCD_MODE_INIT`=1, `LCD_MODE_REF`=0;
  - `LCD_CMD_CLEAR`=0x01, `LCD_CMD_HOME`=0x02;
  - default cycle constants.
- One sub-module, `lcd_delay_cnt`: loadable 20-bit down-counter with `load`, `value` and `zero` outputs. It is shared by the SETUP, PULSE, WAIT and PWRUP phases.

## Test plan
- Use reduced timing params: SETUP=2, E_HIGH=3, CMD_WAIT=5, CLR_WAIT=9.
- Reset release, macro off → all outputs 0, `busy`=0; `lcd_enable`=1, `mode`=1 → 4 E pulses, each 3 cycles high, `data_idx` 0..3, then `lcd_finish` pulse exactly 1 cycle.
- Init burst with `data_in`=0x38,0x0C,0x06,0x01 → LCD_DB matches at each E rise. The fourth byte's wait is 9 cycles; the others wait 5.
- Refresh burst, `mode`=0, `reg_sel`=1, `data_in`=0x40+idx → 16 pulses with RS=1 and DB 0x40..0x4F. Check `lcd_finish` at the expected cycle count (16×10+1 after start).
- `rst`=0 during the 5th refresh byte's PULSE → E=0 on the next edge; no `lcd_finish`; a new request completes normally.
- Back-to-back: `lcd_enable` the cycle after `lcd_finish` → new burst starts with no gap; `lcd_enable` while busy is ignored.
- Macro on, PWR_WAIT=20, `lcd_enable` at cycle 5 → first E rise at cycle 20+1+2; `busy`=1 throughout.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, command codes and default timing for the LCD bus driver
package lcd_pkg;
  typedef enum logic [2:0] {S_PWRUP, S_IDLE, S_SETUP, S_PULSE, S_WAIT, S_DONE} lcd_state_e;
  localparam int CNT_W = 20;
  localparam logic LCD_MODE_INIT = 1'b1;
  localparam logic LCD_MODE_REF = 1'b0;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME = 8'h02;
  localparam int DEF_INIT_BYTES = 4;
  localparam int DEF_REF_BYTES = 16;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_E_HIGH_CYC = 12;
  localparam int DEF_CMD_WAIT_CYC = 2000;
  localparam int DEF_CLR_WAIT_CYC = 82000;
  localparam int DEF_PWR_WAIT_CYC = 750000;
endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable down-counter that stops at zero; times every driver phase
module lcd_delay_cnt import lcd_pkg::*; #(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);
  assign zero = value == '0;
  always_ff @(posedge clk) begin
    if (!rst) value <= RST_VAL;
    else if (load) value <= load_val;
    else if (!zero) value <= value - 1'b1;
  end
endmodule

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: timed HD44780 byte-burst writer (E/RS/RW/DB); LCD_POWERON_WAIT_EN adds a power-on PWRUP delay
module lcd_bus_driver import lcd_pkg::*; #(
  parameter int INIT_BYTES   = DEF_INIT_BYTES,
  parameter int REF_BYTES    = DEF_REF_BYTES,
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int E_HIGH_CYC   = DEF_E_HIGH_CYC,
  parameter int CMD_WAIT_CYC = DEF_CMD_WAIT_CYC,
  parameter int CLR_WAIT_CYC = DEF_CLR_WAIT_CYC,
  parameter int PWR_WAIT_CYC = DEF_PWR_WAIT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_enable,
  input  logic       mode,
  input  logic       reg_sel,
  input  logic [7:0] data_in,
  output logic [3:0] data_idx,
  output logic       lcd_finish,
  output logic       busy,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DB
);
  // SETUP spends one extra cycle capturing data_in; WAIT is one cycle short to keep the byte period
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD = CNT_W'(CMD_WAIT_CYC - 2);
  localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLR_WAIT_CYC - 2);
  lcd_state_e state, next;
  logic mode_lat, rs_lat, load, zero, start, mode_sel, rs_sel, last, clr_cmd;
  logic [CNT_W-1:0] load_val, cnt;
`ifdef LCD_POWERON_WAIT_EN
  localparam lcd_state_e RST_STATE = S_PWRUP;
  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(PWR_WAIT_CYC - 1);
  localparam logic RST_BUSY = 1'b1;
  logic pend;
  assign start = lcd_enable | pend;
  assign mode_sel = pend ? mode_lat : mode;
  assign rs_sel = pend ? rs_lat : reg_sel;
`else
  localparam lcd_state_e RST_STATE = S_IDLE;
  localparam logic [CNT_W-1:0] RST_CNT = '0;
  localparam logic RST_BUSY = 1'b0;
  assign start = lcd_enable;
  assign mode_sel = mode;
  assign rs_sel = reg_sel;
`endif
  assign last = data_idx == 4'(mode_lat == LCD_MODE_INIT ? INIT_BYTES - 1 : REF_BYTES - 1);
  assign clr_cmd = !LCD_RS && (LCD_DB == LCD_CMD_CLEAR || LCD_DB == LCD_CMD_HOME);
  assign LCD_RW = 1'b0;
  lcd_delay_cnt #(.RST_VAL(RST_CNT)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .value(cnt), .zero(zero)
  );
  always_comb begin
    next = state;
    load = 1'b0;
    load_val = '0;
    case (state)
      S_PWRUP: next = zero ? S_IDLE : S_PWRUP;
      S_IDLE: if (start) begin next = S_SETUP; load = 1'b1; load_val = SETUP_LD; end
      S_SETUP: if (zero) begin next = S_PULSE; load = 1'b1; load_val = PULSE_LD; end
      S_PULSE: if (zero) begin next = S_WAIT; load = 1'b1; load_val = clr_cmd ? CLR_LD : CMD_LD; end
      S_WAIT: if (zero) begin next = last ? S_DONE : S_SETUP; load = !last; load_val = SETUP_LD; end
      S_DONE: next = S_IDLE;
      default: next = RST_STATE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RST_STATE;
      mode_lat <= 1'b0;
      rs_lat <= 1'b0;
      data_idx <= '0;
      lcd_finish <= 1'b0;
      busy <= RST_BUSY;
      LCD_E <= 1'b0;
      LCD_RS <= 1'b0;
      LCD_DB <= '0;
`ifdef LCD_POWERON_WAIT_EN
      pend <= 1'b0;
`endif
    end else begin
      state <= next;
      LCD_E <= next == S_PULSE;
      lcd_finish <= state == S_DONE;
      if (state == S_IDLE && start) begin
        mode_lat <= mode_sel;
        rs_lat <= rs_sel;
        data_idx <= '0;
        busy <= 1'b1;
`ifdef LCD_POWERON_WAIT_EN
        pend <= 1'b0;
`endif
      end
      if (state == S_SETUP && cnt == SETUP_LD) begin
        LCD_DB <= data_in;
        LCD_RS <= rs_lat;
      end
      if (state == S_WAIT && zero && !last) data_idx <= data_idx + 4'd1;
      if (state == S_DONE) begin
        busy <= 1'b0;
        data_idx <= '0;
      end
`ifdef LCD_POWERON_WAIT_EN
      if (state == S_PWRUP && lcd_enable && !pend) begin
        pend <= 1'b1;
        mode_lat <= mode;
        rs_lat <= reg_sel;
      end
      if (state == S_PWRUP && zero) busy <= pend | lcd_enable;
`endif
    end
  end
endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver: table-driven and randomized bursts checked against a schedule model of E rises and finish
module tb_lcd_bus_driver;
  localparam int SU = 2, EH = 3, CW = 5, CLW = 9, PW = 20;
  typedef struct {logic m; logic rs; int pat; int n; int fin;} vec_t;
  logic clk = 1'b0, rst = 1'b0, lcd_enable = 1'b0, mode = 1'b0, reg_sel = 1'b0;
  logic [7:0] data_in, LCD_DB;
  logic [3:0] data_idx;
  logic lcd_finish, busy, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] byte_tab [16];
  int total = 0, bad = 0, cyc = 0, e_cnt = 0;
  int rise_c[$], wid[$], fin_c[$], x_c[$], x_fin[$];
  logic [7:0] rise_db[$], x_db[$];
  logic rise_rs[$], rise_busy[$], x_rs[$];
  logic [3:0] rise_idx[$], x_idx[$];
  lcd_bus_driver #(.SETUP_CYC(SU), .E_HIGH_CYC(EH), .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(CLW), .PWR_WAIT_CYC(PW)) dut (
    .clk(clk), .rst(rst), .lcd_enable(lcd_enable), .mode(mode), .reg_sel(reg_sel), .data_in(data_in),
    .data_idx(data_idx), .lcd_finish(lcd_finish), .busy(busy), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_DB(LCD_DB)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign data_in = byte_tab[data_idx];
  always @(negedge clk) begin
    if (LCD_E && e_cnt == 0) begin
      rise_c.push_back(cyc);
      rise_db.push_back(LCD_DB);
      rise_rs.push_back(LCD_RS);
      rise_idx.push_back(data_idx);
      rise_busy.push_back(busy);
    end
    if (!LCD_E && e_cnt != 0) wid.push_back(e_cnt);
    if (lcd_finish) fin_c.push_back(cyc);
    e_cnt <= LCD_E ? e_cnt + 1 : 0;
  end
  task automatic check(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // Schedule model: byte j rises SETUP+1 after its slot starts; each slot lasts SETUP+E_HIGH+wait
  function automatic int model(int k, logic m, logic rs);
    int t = k;
    int n = m ? 4 : 16;
    for (int j = 0; j < n; j++) begin
      x_c.push_back(t + 1 + SU);
      x_db.push_back(byte_tab[j]);
      x_rs.push_back(rs);
      x_idx.push_back(4'(j));
      t += SU + EH + ((!rs && (byte_tab[j] == 8'h01 || byte_tab[j] == 8'h02)) ? CLW : CW);
    end
    x_fin.push_back(t + 1);
    return t + 1;
  endfunction
  task automatic clear_q();
    rise_c.delete(); rise_db.delete(); rise_rs.delete(); rise_idx.delete(); rise_busy.delete();
    wid.delete(); fin_c.delete(); x_c.delete(); x_db.delete(); x_rs.delete(); x_idx.delete(); x_fin.delete();
  endtask
  task automatic compare(string tag);
    check({tag, " rise count"}, rise_c.size(), x_c.size());
    for (int i = 0; i < x_c.size() && i < rise_c.size(); i++) begin
      check({tag, " rise cycle"}, rise_c[i], x_c[i]);
      check({tag, " DB"}, int'(rise_db[i]), int'(x_db[i]));
      check({tag, " RS"}, int'(rise_rs[i]), int'(x_rs[i]));
      check({tag, " data_idx"}, int'(rise_idx[i]), int'(x_idx[i]));
      check({tag, " busy"}, int'(rise_busy[i]), 1);
    end
    check({tag, " pulse count"}, wid.size(), x_c.size());
    foreach (wid[i]) check({tag, " E width"}, wid[i], EH);
    check({tag, " finish count"}, fin_c.size(), x_fin.size());
    for (int i = 0; i < x_fin.size() && i < fin_c.size(); i++) check({tag, " finish cycle"}, fin_c[i], x_fin[i]);
    clear_q();
  endtask
  task automatic fill(int pat);
    for (int i = 0; i < 16; i++) byte_tab[i] = pat == 1 ? 8'(8'h40 + i) : pat == 2 ? 8'h02 : 8'h00;
    if (pat == 0) begin byte_tab[0] = 8'h38; byte_tab[1] = 8'h0C; byte_tab[2] = 8'h06; byte_tab[3] = 8'h01; end
    if (pat == 3) begin byte_tab[0] = 8'h01; byte_tab[1] = 8'h02; byte_tab[2] = 8'h03; byte_tab[3] = 8'h00; end
  endtask
  task automatic start(logic m, logic rs, output int k);
    @(negedge clk);
    lcd_enable = 1'b1; mode = m; reg_sel = rs; k = cyc + 1;
    @(negedge clk);
    lcd_enable = 1'b0; mode = 1'($urandom); reg_sel = 1'($urandom);
  endtask
  task automatic wait_fin(int lim);
    int n = 0;
    while (!lcd_finish && n < lim) begin @(negedge clk); n++; end
    check("finish timeout", n < lim ? 0 : 1, 0);
  endtask
  initial begin
    vec_t tab[6];
    int k, k2, c0, nb;
    logic m, rs, rb;
    tab[0] = '{1'b1, 1'b0, 0, 4, 45};
    tab[1] = '{1'b0, 1'b1, 1, 16, 161};
    tab[2] = '{1'b0, 1'b1, 2, 16, 161};
    tab[3] = '{1'b1, 1'b0, 3, 4, 49};
    tab[4] = '{1'b1, 1'b1, 3, 4, 41};
    tab[5] = '{1'b0, 1'b0, 2, 16, 225};
    fill(0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    c0 = cyc;
`ifdef LCD_POWERON_WAIT_EN
    rb = 1'b1;
    repeat (5) @(negedge clk);
    lcd_enable = 1'b1; mode = 1'b1; reg_sel = 1'b0;
    @(negedge clk);
    lcd_enable = 1'b0; mode = 1'b0; reg_sel = 1'b1;
    nb = 0;
    while (cyc < c0 + PW + 1) begin nb += int'(!busy); @(negedge clk); end
    check("pwrup busy low samples", nb, 0);
    void'(model(c0 + PW + 1, 1'b1, 1'b0));
    wait_fin(600);
    repeat (3) @(negedge clk);
    compare("pwrup");
`else
    rb = 1'b0;
    @(negedge clk);
    check("rst E", int'(LCD_E), 0);
    check("rst RS", int'(LCD_RS), 0);
    check("rst RW", int'(LCD_RW), 0);
    check("rst DB", int'(LCD_DB), 0);
    check("rst idx", int'(data_idx), 0);
    check("rst finish", int'(lcd_finish), 0);
    check("rst busy", int'(busy), 0);
`endif
    foreach (tab[i]) begin
      fill(tab[i].pat);
      start(tab[i].m, tab[i].rs, k);
      void'(model(k, tab[i].m, tab[i].rs));
      wait_fin(600);
      repeat (3) @(negedge clk);
      check("vec pulses", rise_c.size(), tab[i].n);
      check("vec finish offset", fin_c.size() > 0 ? fin_c[0] - k : -1, tab[i].fin);
      compare("vec");
    end
    for (int r = 0; r < 6; r++) begin
      m = 1'($urandom); rs = 1'($urandom);
      for (int i = 0; i < 16; i++) begin
        nb = int'($urandom_range(0, 3));
        byte_tab[i] = nb == 0 ? 8'h01 : nb == 1 ? 8'h02 : 8'($urandom);
      end
      start(m, rs, k);
      void'(model(k, m, rs));
      wait_fin(600);
      repeat (3) @(negedge clk);
      compare("rand");
    end
    fill(1);
    start(1'b0, 1'b1, k);
    while (cyc < k + 44) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort E", int'(LCD_E), 0);
    check("abort busy", int'(busy), int'(rb));
    check("abort idx", int'(data_idx), 0);
    check("abort DB", int'(LCD_DB), 0);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check("abort rises", rise_c.size(), 5);
    check("abort no finish", fin_c.size(), 0);
    clear_q();
    start(1'b0, 1'b1, k);
    void'(model(k, 1'b0, 1'b1));
    wait_fin(600);
    repeat (3) @(negedge clk);
    compare("after abort");
    fill(0);
    start(1'b1, 1'b0, k);
    void'(model(k, 1'b1, 1'b0));
    repeat (20) @(negedge clk);
    lcd_enable = 1'b1; mode = 1'b0; reg_sel = 1'b1;
    @(negedge clk);
    lcd_enable = 1'b0;
    wait_fin(600);
    lcd_enable = 1'b1; mode = 1'b1; reg_sel = 1'b0; k2 = cyc + 1;
    void'(model(k2, 1'b1, 1'b0));
    @(negedge clk);
    lcd_enable = 1'b0;
    wait_fin(600);
    repeat (3) @(negedge clk);
    compare("b2b");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
